// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//
// Conditions raw board switch levels for the adder/display logic. Each bit is
// brought into the clk domain by a two-flop synchroniser and then filtered by
// its own stability counter. A new level is accepted only after it has been
// seen for STABLE_COUNT consecutive enabled cycles. Every accepted change
// raises a one-cycle rise or fall strobe.
//
// Parameters
//   WIDTH        number of independent switch channels
//   CNT_W        width of each per-channel stability counter
//   STABLE_COUNT consecutive mismatching cycles needed before a change is
//                accepted (1 .. 2^CNT_W-1)
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   ena        filter enable; when low, counters and db_out hold and the
//              strobes are forced low, but the synchroniser keeps sampling
//   sw_in      raw asynchronous switch levels
//   db_out     debounced levels (registered)
//   rise       one-cycle strobe on an accepted 0->1 change, per bit
//   fall       one-cycle strobe on an accepted 1->0 change, per bit
//   any_change registered OR of all rise/fall bits, aligned with them
// -----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int              WIDTH        = 8,
  parameter int              CNT_W        = 24,
  parameter logic [CNT_W-1:0] STABLE_COUNT = 24'd250_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  // Counter value at which the next mismatching cycle completes the window.
  // Acceptance happens here, so the counter never reaches STABLE_COUNT.
  localparam logic [CNT_W-1:0] LIMIT    = STABLE_COUNT - CNT_ONE;

  logic [WIDTH-1:0]            sync1_r;
  logic [WIDTH-1:0]            sync2_r;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0]            db_r;
  logic [WIDTH-1:0]            rise_r;
  logic [WIDTH-1:0]            fall_r;
  logic                        any_r;

  logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt_s;
  logic [WIDTH-1:0]            db_nxt_s;
  logic [WIDTH-1:0]            rise_nxt_s;
  logic [WIDTH-1:0]            fall_nxt_s;

  // Per-channel filter decision: reset, advance, or accept the synchronised level.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    db_nxt_s   = db_r;
    rise_nxt_s = {WIDTH{1'b0}};
    fall_nxt_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_r[i] == db_r[i]) begin
        // Any mismatch shorter than the window is forgotten here.
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (cnt_r[i] != LIMIT) begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end else begin
        cnt_nxt_s[i]  = CNT_ZERO;
        db_nxt_s[i]   = sync2_r[i];
        rise_nxt_s[i] = sync2_r[i];
        fall_nxt_s[i] = ~sync2_r[i];
      end
    end
  end

  // Synchroniser, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
      cnt_r   <= {WIDTH{CNT_ZERO}};
      db_r    <= {WIDTH{1'b0}};
      rise_r  <= {WIDTH{1'b0}};
      fall_r  <= {WIDTH{1'b0}};
      any_r   <= 1'b0;
    end else begin
      // The synchroniser is free-running so ena never leaves stale levels behind.
      sync1_r <= sw_in;
      sync2_r <= sync1_r;
      if (ena) begin
        cnt_r  <= cnt_nxt_s;
        db_r   <= db_nxt_s;
        rise_r <= rise_nxt_s;
        fall_r <= fall_nxt_s;
        any_r  <= |(rise_nxt_s | fall_nxt_s);
      end else begin
        cnt_r  <= cnt_r;
        db_r   <= db_r;
        rise_r <= {WIDTH{1'b0}};
        fall_r <= {WIDTH{1'b0}};
        any_r  <= 1'b0;
      end
    end
  end

  assign db_out     = db_r;
  assign rise       = rise_r;
  assign fall       = fall_r;
  assign any_change = any_r;

endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
//
// Directed bench for switch_debouncer with WIDTH=8 and STABLE_COUNT=4.
// Inputs change 1 time unit after a rising edge; that next rising edge is
// called E. Outputs are sampled 1 time unit after each edge, so after n calls
// of tick() following an input change the bench observes the state left by
// edge E+n-1. A change is accepted at edge E+5 (two synchroniser stages plus
// four counted cycles), i.e. it is visible after the sixth tick.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] sw_in;
  logic [7:0] db_out;
  logic [7:0] rise;
  logic [7:0] fall;
  logic       any_change;

  int checks = 0;
  int errors = 0;

  switch_debouncer #(
    .WIDTH       (8),
    .CNT_W       (24),
    .STABLE_COUNT(24'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .sw_in     (sw_in),
    .db_out    (db_out),
    .rise      (rise),
    .fall      (fall),
    .any_change(any_change)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [7:0] e_db, input logic [7:0] e_rise,
                      input logic [7:0] e_fall, input logic e_any);
    chk({tag, ".db_out"}, db_out, e_db);
    chk({tag, ".rise"}, rise, e_rise);
    chk({tag, ".fall"}, fall, e_fall);
    chk({tag, ".any_change"}, {7'd0, any_change}, {7'd0, e_any});
  endtask

  initial begin
    rst   = 1'b1;
    ena   = 1'b1;
    sw_in = 8'h00;

    // Reset held for two cycles.
    tick();
    tick();
    outs("reset", 8'h00, 8'h00, 8'h00, 1'b0);
    rst = 1'b0;

    // 1. Clean rise on bit 0: nothing before E+5, one-cycle strobe at E+5.
    sw_in = 8'h01;
    for (int k = 0; k < 5; k++) begin
      tick();
      outs("rise1_wait", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    tick();
    outs("rise1_accept", 8'h01, 8'h01, 8'h00, 1'b1);
    tick();
    outs("rise1_after", 8'h01, 8'h00, 8'h00, 1'b0);

    // 2a. Three-cycle pulse on bit 1 is rejected.
    sw_in = 8'h03;
    tick();
    tick();
    tick();
    sw_in = 8'h01;
    for (int k = 0; k < 8; k++) begin
      tick();
      outs("glitch3", 8'h01, 8'h00, 8'h00, 1'b0);
    end

    // 2b. Four-cycle pulse on bit 1: rise at E+5, fall four cycles after it drops.
    sw_in = 8'h03;
    for (int k = 0; k < 4; k++) tick();
    sw_in = 8'h01;
    tick();
    tick();
    outs("pulse4_rise", 8'h03, 8'h02, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      outs("pulse4_hold", 8'h03, 8'h00, 8'h00, 1'b0);
    end
    tick();
    outs("pulse4_fall", 8'h01, 8'h00, 8'h02, 1'b1);
    tick();
    outs("pulse4_after", 8'h01, 8'h00, 8'h00, 1'b0);

    // 3. Bit 2 bounces 1,0,1,0,1 then holds 1: single rise at E+9.
    for (int k = 0; k < 5; k++) begin
      sw_in = (k % 2 == 0) ? 8'h05 : 8'h01;
      tick();
      outs("bounce", 8'h01, 8'h00, 8'h00, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      outs("bounce_settle", 8'h01, 8'h00, 8'h00, 1'b0);
    end
    tick();
    outs("bounce_rise", 8'h05, 8'h04, 8'h00, 1'b1);
    tick();
    outs("bounce_after", 8'h05, 8'h00, 8'h00, 1'b0);

    // 4. Return to zero (two simultaneous falls), then 00 -> A5 in one step.
    sw_in = 8'h00;
    for (int k = 0; k < 6; k++) tick();
    outs("multi_clear", 8'h00, 8'h00, 8'h05, 1'b1);
    tick();
    sw_in = 8'hA5;
    for (int k = 0; k < 5; k++) tick();
    outs("multi_wait", 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    outs("multi_accept", 8'hA5, 8'hA5, 8'h00, 1'b1);
    tick();
    outs("multi_after", 8'hA5, 8'h00, 8'h00, 1'b0);

    // 5. Enable pause: two counted cycles, ten paused, then two more.
    sw_in = 8'h00;
    for (int k = 0; k < 6; k++) tick();
    outs("ena_clear", 8'h00, 8'h00, 8'hA5, 1'b1);
    tick();
    sw_in = 8'h01;
    for (int k = 0; k < 4; k++) tick();
    ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      outs("ena_paused", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    ena = 1'b1;
    tick();
    outs("ena_resume", 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    outs("ena_accept", 8'h01, 8'h01, 8'h00, 1'b1);

    // 6. Reset at counter value 3 with all switches high, then full latency.
    sw_in = 8'hFF;
    for (int k = 0; k < 5; k++) tick();
    outs("rstmid_before", 8'h01, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    tick();
    outs("rstmid_reset", 8'h00, 8'h00, 8'h00, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      outs("rstmid_wait", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    tick();
    outs("rstmid_accept", 8'hFF, 8'hFF, 8'h00, 1'b1);
    tick();
    outs("rstmid_after", 8'hFF, 8'h00, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Input-conditioning stage between the board switches (`ui_in`) and the adder/display logic in the Tiny Tapeout top level. Each switch bit is synchronised into the `clk` domain, filtered by a per-bit stability counter, and presented as a clean level. A one-cycle rise or fall strobe accompanies every accepted change, so downstream stages (the half adder operands, counters) see glitch-free inputs.

## Interface

Parameters:
- `WIDTH`, 8: number of independent switch channels.
- `CNT_W`, 24: width of each per-channel stability counter.
- `STABLE_COUNT`, 24'd250_000: consecutive cycles a synchronised input must differ from the current output before it is accepted (5 ms at 50 MHz). Must be ≥1 and ≤ 2^CNT_W − 1.

Ports:
- `clk`, input, 1: single clock; all state is updated on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `ena`, input, 1: design enable from the top level. When 0, filtering pauses.
- `sw_in`, input, WIDTH: raw asynchronous switch levels.
- `db_out`, output, WIDTH: debounced levels, registered.
- `rise`, output, WIDTH: one-cycle strobe, set when the corresponding `db_out` bit goes 0→1.
- `fall`, output, WIDTH: one-cycle strobe, set when the corresponding `db_out` bit goes 1→0.
- `any_change`, output, 1: registered OR of all `rise` and `fall` bits, aligned with them.

## Operation

- **Synchroniser.** Per bit, two flops: `sync1 <= sw_in`, then `sync2 <= sync1`. `sync2` is the only value the filter examines.
- **Filter.** Each bit has its own counter `cnt[i]`, CNT_W wide. Each edge with `ena`=1:
  - If `sync2[i] == db_out[i]`: `cnt[i] <= 0`. Any glitch shorter than the window is discarded.
  - If they differ and `cnt[i] != STABLE_COUNT−1`: `cnt[i] <= cnt[i]+1`.
  - If they differ and `cnt[i] == STABLE_COUNT−1`: `db_out[i] <= sync2[i]`, `cnt[i] <= 0`, and the matching `rise[i]` or `fall[i]` is set to 1 for that cycle.
- **Strobes.** `rise` and `fall` are 0 on every cycle in which no acceptance occurs. A bit never asserts `rise` and `fall` together.
- **Channel independence.** Channels are fully independent. Several bits may be accepted in the same cycle, each with its own strobe. `any_change` is 1 in that cycle.
- **Counter range.** The counter never reaches STABLE_COUNT, so it never wraps.
- **Enable low.** With `ena`=0:
  - All `cnt` hold their value.
  - `db_out` holds.
  - `rise`, `fall` and `any_change` are forced to 0.
  - Synchroniser flops keep sampling.
- **Reset.** `rst`=1 at an edge clears `sync1`, `sync2`, all `cnt`, `db_out`, `rise`, `fall` and `any_change` to 0. This takes priority over `ena` and can occur mid-count. After reset, a switch held at 1 is accepted as a normal 0→1 change and produces a `rise` strobe.

## Timing

- Reset values of all outputs are 0. Outputs are valid on the first edge after `rst` deasserts.
- **Latency.** Suppose `sw_in[i]` changes before edge E and stays stable, with `ena`=1.
  - `sync2[i]` reflects the change after edge E+1.
  - `db_out[i]`, together with the `rise`/`fall`/`any_change` strobe, updates at edge E+1+STABLE_COUNT.
  - With STABLE_COUNT=1, this is edge E+2, so there is no filtering beyond the synchroniser.
- **Glitch rejection.** A mismatch lasting fewer than STABLE_COUNT consecutive `sync2` cycles produces no output change.
- **Simultaneous events.** A bit reverting to equality in the same cycle it would otherwise have been accepted cannot occur, because acceptance depends only on the current mismatch. Acceptance and counter reset happen together.
- Strobes last exactly one cycle. Repeated toggles each produce a strobe only after a full new window.
- **No combinational paths.** There is no combinational path from `sw_in` to any output.

## Test plan

All scenarios use STABLE_COUNT=4 and WIDTH=8.

1. **Reset and clean rise.** Hold `rst` for 2 cycles, then drive `sw_in`=8'h01 before edge E → `db_out`=8'h01, `rise`=8'h01 and `any_change`=1 at edge E+5, all for one cycle. `db_out` stays 0 before E+5.
2. **Glitch rejection.** From `db_out`=0, pulse bit 1 high for 3 cycles, then low → `db_out`, `rise` and `fall` stay 0 throughout. A 4-cycle pulse (counted at `sync2`) → `rise[1]` strobe, followed later by `fall[1]` once the input has been low for 4 cycles.
3. **Bouncing edge.** Bit 2 toggles 1,0,1,0,1 on successive cycles, then holds 1 → a single `rise[2]` strobe, 4 cycles after the final stable 1 reaches `sync2`.
4. **Multi-channel.** `sw_in` changes 8'h00→8'hA5 in one cycle → `db_out`=8'hA5, `rise`=8'hA5 and `any_change`=1 in the same single cycle, with `fall`=0.
5. **Enable pause.** Start a 0→1 change on bit 0, then drop `ena` after 2 counted cycles and hold it low for 10 cycles, then raise it → acceptance after 2 further counted cycles, and no strobe while `ena`=0.
6. **Reset mid-count.** Assert `rst` at counter value 3 with `sw_in`=8'hFF → all outputs 0 on the next cycle. After deassertion, a full 2+4-cycle latency passes before `rise`=8'hFF.
